// File: rtl/sdff_scan_bank.sv
// sdff_scan_bank: a bank of WIDTH scan flip-flops with a built-in enable and a scan-session controller.
// The WIDTH bits form CHAINS equal scan chains of length L = WIDTH/CHAINS.
// The controller counts shift cycles. It pulses CHAIN_DONE after every L consecutive shifts.
// It sets PARTIAL when a scan session ends before a full chain load.
// Ports:
//   CK         in  rising-edge clock
//   RN         in  synchronous active-low reset
//   D          in  functional data (WIDTH)
//   E          in  functional load enable
//   SE         in  scan enable (has priority over E)
//   SI         in  scan-in, one bit per chain (CHAINS)
//   Q          out register contents (WIDTH)
//   SO         out scan-out, one bit per chain, taken directly from Q (CHAINS)
//   SHIFT_CNT  out consecutive shifts in the current session ($clog2(L+1))
//   CHAIN_DONE out one-cycle pulse after L consecutive shifts
//   PARTIAL    out sticky flag: the last session ended mid-chain
// Requires WIDTH % CHAINS == 0 and WIDTH/CHAINS >= 2.
module sdff_scan_bank #(
  parameter int unsigned             WIDTH   = 32,
  parameter int unsigned             CHAINS  = 4,
  parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
  input  logic                                        CK,
  input  logic                                        RN,
  input  logic [WIDTH-1:0]                            D,
  input  logic                                        E,
  input  logic                                        SE,
  input  logic [CHAINS-1:0]                           SI,
  output logic [WIDTH-1:0]                            Q,
  output logic [CHAINS-1:0]                           SO,
  output logic [$clog2((WIDTH/CHAINS)+1)-1:0]         SHIFT_CNT,
  output logic                                        CHAIN_DONE,
  output logic                                        PARTIAL
);

  localparam int unsigned L  = WIDTH / CHAINS;
  localparam int unsigned CW = $clog2(L + 1);

  typedef enum logic {
    ST_FUNC  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             partial_q, partial_d;
  logic [WIDTH-1:0] shifted;

  // Each chain shifts toward its low bit; SI enters at the chain's top bit.
  always_comb begin
    shifted = data_q;
    for (int c = 0; c < int'(CHAINS); c++) begin
      shifted[c*L +: L] = {SI[c], data_q[c*L+1 +: L-1]};
    end
  end

  // Next-state logic. The order of decisions is reset, then shift, then load, then hold.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    partial_d = partial_q;

    if (SE) begin
      data_d  = shifted;
      state_d = ST_SHIFT;
      // The count is always zero in FUNC, so the first shift of a session lands on 1.
      if (cnt_q == CW'(L - 1)) begin
        cnt_d     = '0;
        done_d    = 1'b1;
        partial_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      if (state_q == ST_SHIFT) begin
        state_d = ST_FUNC;
        // An exit on a chain boundary leaves PARTIAL as it was.
        if (cnt_q != '0) begin
          partial_d = 1'b1;
          cnt_d     = '0;
        end
      end
      if (E) begin
        data_d = D;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q   <= ST_FUNC;
      data_q    <= RST_VAL;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      partial_q <= partial_d;
    end
  end

  // SO is the low bit of each chain, with no extra register stage.
  always_comb begin
    SO = '0;
    for (int c = 0; c < int'(CHAINS); c++) begin
      SO[c] = data_q[c*L];
    end
  end

  assign Q          = data_q;
  assign SHIFT_CNT  = cnt_q;
  assign CHAIN_DONE = done_q;
  assign PARTIAL    = partial_q;

endmodule

// File: tb/tb_sdff_scan_bank.sv
// Bench for sdff_scan_bank with WIDTH=8, CHAINS=2 (L=4) and RST_VAL=0.
// A reference model computes the expected outputs when each stimulus is applied.
// The expected values are queued, then popped and compared after the clock edge.
module tb_sdff_scan_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned NC = 2;

  typedef struct packed {
    logic [7:0] q;
    logic [2:0] cnt;
    logic       done;
    logic       part;
  } exp_t;

  logic          CK;
  logic          RN;
  logic [W-1:0]  D;
  logic          E;
  logic          SE;
  logic [NC-1:0] SI;
  logic [W-1:0]  Q;
  logic [NC-1:0] SO;
  logic [2:0]    SHIFT_CNT;
  logic          CHAIN_DONE;
  logic          PARTIAL;

  sdff_scan_bank #(.WIDTH(W), .CHAINS(NC), .RST_VAL(8'h00)) dut (
    .CK(CK), .RN(RN), .D(D), .E(E), .SE(SE), .SI(SI),
    .Q(Q), .SO(SO), .SHIFT_CNT(SHIFT_CNT), .CHAIN_DONE(CHAIN_DONE), .PARTIAL(PARTIAL)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [7:0] m_q;
  logic [2:0] m_cnt;
  logic       m_done;
  logic       m_part;
  logic       m_shift;
  logic       m_valid = 1'b0;
  exp_t       sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input logic rn, input logic [7:0] d, input logic e,
                      input logic se, input logic [1:0] si);
    logic [7:0] nq;
    exp_t       ex;
    exp_t       got;
    RN = rn; D = d; E = e; SE = se; SI = si;
    #1;
    if (m_valid) check("so", 32'(SO), 32'({m_q[4], m_q[0]}));
    if (!rn) begin
      m_q = 8'h00; m_cnt = 3'd0; m_done = 1'b0; m_part = 1'b0; m_shift = 1'b0;
      m_valid = 1'b1;
    end else if (se) begin
      for (int i = 0; i < 8; i++) begin
        if (i % 4 == 3) nq[i] = si[i / 4];
        else            nq[i] = m_q[i + 1];
      end
      m_q = nq;
      m_shift = 1'b1;
      m_done = 1'b0;
      if (m_cnt == 3'd3) begin
        m_cnt = 3'd0; m_done = 1'b1; m_part = 1'b0;
      end else begin
        m_cnt = m_cnt + 3'd1;
      end
    end else begin
      m_done = 1'b0;
      if (m_shift && m_cnt != 3'd0) begin
        m_part = 1'b1; m_cnt = 3'd0;
      end
      m_shift = 1'b0;
      if (e) m_q = d;
    end
    ex.q = m_q; ex.cnt = m_cnt; ex.done = m_done; ex.part = m_part;
    sb.push_back(ex);
    @(posedge CK);
    #1;
    ex = sb.pop_front();
    got.q = Q; got.cnt = SHIFT_CNT; got.done = CHAIN_DONE; got.part = PARTIAL;
    check("q",          32'(got.q),    32'(ex.q));
    check("shift_cnt",  32'(got.cnt),  32'(ex.cnt));
    check("chain_done", 32'(got.done), 32'(ex.done));
    check("partial",    32'(got.part), 32'(ex.part));
  endtask

  logic [3:0] si0_seq;
  logic [3:0] so0_seq;

  initial begin
    RN = 1'b0; D = '0; E = 1'b0; SE = 1'b0; SI = '0;

    // Reset overrides both SE and E.
    step(1'b0, 8'hFF, 1'b1, 1'b1, 2'b11);
    check("rst_q", 32'(Q), 32'h00);
    check("rst_cnt", 32'(SHIFT_CNT), 32'd0);

    // Load, then hold.
    step(1'b1, 8'hA5, 1'b1, 1'b0, 2'b00);
    check("load_q", 32'(Q), 32'hA5);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 2'b00);
    check("hold_q", 32'(Q), 32'hA5);

    // Full chain load from A5. SI[0] = 1,0,1,1 and SI[1] = 0. SO[0] must read 1,0,1,0 before each edge.
    si0_seq = 4'b1101;
    so0_seq = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      SE = 1'b1;
      SI = {1'b0, si0_seq[k]};
      #1;
      check("so0_seq", 32'(SO[0]), 32'(so0_seq[k]));
      step(1'b1, 8'h00, 1'b0, 1'b1, {1'b0, si0_seq[k]});
      check("cnt_seq", 32'(SHIFT_CNT), 32'((k + 1) % 4));
    end
    check("full_q", 32'(Q), 32'h0D);
    check("full_done", 32'(CHAIN_DONE), 32'd1);
    // This exit lands on a chain boundary, so PARTIAL stays clear.
    step(1'b1, 8'h00, 1'b0, 1'b0, 2'b00);
    check("aligned_exit_partial", 32'(PARTIAL), 32'd0);
    check("done_drops", 32'(CHAIN_DONE), 32'd0);

    // Abort after two shifts of ones into A5. The nibbles go 5->A->D and A->D->E.
    step(1'b1, 8'hA5, 1'b1, 1'b0, 2'b00);
    step(1'b1, 8'h00, 1'b0, 1'b1, 2'b11);
    step(1'b1, 8'h00, 1'b0, 1'b1, 2'b11);
    step(1'b1, 8'h00, 1'b0, 1'b0, 2'b00);
    check("abort_q", 32'(Q), 32'hED);
    check("abort_partial", 32'(PARTIAL), 32'd1);
    check("abort_cnt", 32'(SHIFT_CNT), 32'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 8'h00, 1'b0, 1'b1, 2'b00);
    check("partial_cleared", 32'(PARTIAL), 32'd0);

    // SE beats E. D must not be loaded.
    step(1'b1, 8'h00, 1'b0, 1'b0, 2'b00);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 2'b00);
    step(1'b1, 8'hFF, 1'b1, 1'b1, 2'b00);
    check("prio_not_loaded", 32'(Q != 8'hFF), 32'd1);
    check("prio_cnt", 32'(SHIFT_CNT), 32'd1);

    // Reset after a third shift drops the session without raising PARTIAL.
    step(1'b1, 8'hFF, 1'b1, 1'b1, 2'b01);
    step(1'b1, 8'hFF, 1'b1, 1'b1, 2'b10);
    step(1'b0, 8'hFF, 1'b1, 1'b1, 2'b11);
    check("midrst_q", 32'(Q), 32'h00);
    check("midrst_partial", 32'(PARTIAL), 32'd0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 2'b00);
    check("midrst_no_done", 32'(CHAIN_DONE), 32'd0);

    // Random mix of the cases above.
    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 31) != 0), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
